twinkle_array: RTL and testbench
================================

// Module: twinkle_array
// PURPOSE
// Parametrised successor to the fixed 24-LED random twinkle path: N channels of W-bit
// intensity, each with a rise/hold/fall envelope, a sigma-delta PWM output per channel,
// LFSR-driven random triggering with density control, a concurrency cap and a manual
// trigger port. Sits between the UART command decoder and the LED pins.
// PARAMETERS
// CHANNELS    24  number of LED channels
// IW          3   intensity bits per channel; full scale FS = 2^IW-1
// TICK_WIDTH  20  tick divider width; one tick every 2^TICK_WIDTH clk cycles
// HOLD_W      4   width of hold_ticks
// MAX_ACTIVE  4   maximum channels simultaneously out of IDLE
// PORTS
// clk          in   1            system clock (14.7 MHz)
// rst_n        in   1            asynchronous active-low reset
// enable       in   1            1 = random triggering allowed
// density      in   8            random trigger threshold (0 = no random triggers)
// hold_ticks   in   HOLD_W       ticks held at FS before falling
// trig_valid   in   1            manual trigger strobe, 1 cycle
// trig_idx     in   8            channel for manual trigger
// tick         out  1            1-cycle pulse on divider wrap
// active_count out  $clog2(CHANNELS+1)  channels not in IDLE
// intensities  out  CHANNELS*IW  channel c at [c*IW +: IW]
// leds         out  CHANNELS     PWM outputs
// BEHAVIOUR
// - Reset (async, rst_n=0): divider=0, tick=0, LFSR=16'hFFFF, all channels IDLE,
//   intensities=0, PWM accumulators=0, leds=0, active_count=0, pending trigger cleared.
// - Divider: counts every clk; tick=1 for exactly one cycle when count wraps to 0.
// - LFSR: 16-bit Galois, taps 16'h1002D, advances on tick only; trigger decode uses the
//   pre-advance value r.
// - Random candidate on tick: idx=r[6:0]; valid iff enable && idx<CHANNELS && r[15:8]<density.
// - Manual trigger: trig_valid with trig_idx<CHANNELS latched as pending (later strobe
//   overwrites, last wins); trig_idx>=CHANNELS ignored. Pending consumed and cleared on
//   next tick; takes priority over random candidate that tick (random discarded).
//   Strobe coinciding with tick is applied on that tick.
// - Acceptance: one trigger max per tick; accepted only if target channel IDLE and
//   active_count<MAX_ACTIVE (count sampled before this tick's updates). Rejected
//   triggers are dropped, not queued.
// - Channel FSM, all transitions on tick only:
//   IDLE: intensity 0; accepted trigger -> RISE.
//   RISE: intensity+1 per tick; on the tick it reaches FS -> HOLD, hold_cnt=hold_ticks.
//   HOLD: hold_cnt==0 -> FALL, else hold_cnt-1. hold_ticks=0 => exactly 1 tick at FS.
//   FALL: intensity-1 per tick; on the tick it reaches 0 -> IDLE.
//   Envelope length from trigger: FS rise + (hold_ticks+1) + FS fall ticks; no wrap.
// - enable=0 stops random triggers only; running envelopes complete; manual still works.
// - PWM per channel: acc[IW:0] <= acc[IW-1:0] + intensity every clk; led = acc[IW].
//   Duty = intensity/2^IW exactly over 2^IW cycles; intensity 0 => led constantly 0.
// - active_count registered, updated same cycle as FSM states; equals popcount(!IDLE).
// - Reset mid-envelope: immediate return to reset values; no resume.
// TESTING (sim with TICK_WIDTH=2, CHANNELS=24, IW=3)
// - Reset release: tick period 4 clk, 1-cycle pulse; all leds/intensities 0, count 0.
// - Manual trig_idx=5, hold_ticks=2: ch5 intensity 1..7 over 7 ticks, 7 for 3 ticks,
//   6..0 over 7 ticks, IDLE after 17 ticks; active_count 1 throughout, then 0.
// - PWM: ch5 held at 3 -> led5 high exactly 3 of every 8 clk; at 7 -> 7 of 8.
// - Cap: manual triggers to ch0..5 on successive ticks -> ch0..3 start, ch4,ch5 dropped,
//   active_count saturates at 4; retrigger of active ch0 ignored.
// - density=0, enable=1 for 4096 ticks -> no channel leaves IDLE; density=255 -> random
//   starts occur, only at idx<24, and never exceed 4 active.
// - trig_idx=30 ignored; rst_n low mid-HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/twinkle_array.sv
// N-channel LED twinkle engine: rise/hold/fall envelopes with random and manual triggering,
// a cap on concurrently lit channels, and a first-order sigma-delta PWM per channel.
module twinkle_array #(
    parameter int unsigned CHANNELS   = 24,
    parameter int unsigned IW         = 3,
    parameter int unsigned TICK_WIDTH = 20,
    parameter int unsigned HOLD_W     = 4,
    parameter int unsigned MAX_ACTIVE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [7:0]                    density,
    input  logic [HOLD_W-1:0]             hold_ticks,
    input  logic                          trig_valid,
    input  logic [7:0]                    trig_idx,
    output logic                          tick,
    output logic [$clog2(CHANNELS+1)-1:0] active_count,
    output logic [CHANNELS*IW-1:0]        intensities,
    output logic [CHANNELS-1:0]           leds
);

    localparam int unsigned CW = $clog2(CHANNELS + 1);
    localparam logic [IW-1:0] FS = {IW{1'b1}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RISE = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_FALL = 2'd3;

    logic [TICK_WIDTH-1:0] div_q, div_d;
    logic                  tick_q, tick_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [7:0]            pend_idx_q, pend_idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            st_q   [CHANNELS];
    logic [1:0]            st_d   [CHANNELS];
    logic [IW-1:0]         int_q  [CHANNELS];
    logic [IW-1:0]         int_d  [CHANNELS];
    logic [HOLD_W-1:0]     hcnt_q [CHANNELS];
    logic [HOLD_W-1:0]     hcnt_d [CHANNELS];
    logic [IW:0]           acc_q  [CHANNELS];
    logic [IW:0]           acc_d  [CHANNELS];

    logic       man_ok_c;
    logic       rnd_ok_c;
    logic       trig_c;
    logic [7:0] trig_sel_c;

    // Divider, LFSR, pending manual trigger and the single per-tick trigger selection
    always_comb begin
        div_d      = div_q + TICK_WIDTH'(1);
        tick_d     = &div_q;
        lfsr_d     = lfsr_q;
        pend_vld_d = pend_vld_q;
        pend_idx_d = pend_idx_q;
        trig_c     = 1'b0;
        trig_sel_c = 8'd0;

        man_ok_c = trig_valid && (trig_idx < 8'(CHANNELS));
        rnd_ok_c = enable && ({1'b0, lfsr_q[6:0]} < 8'(CHANNELS)) && (lfsr_q[15:8] < density);

        if (man_ok_c) begin
            pend_vld_d = 1'b1;
            pend_idx_d = trig_idx;
        end

        if (tick_q) begin
            lfsr_d     = {lfsr_q[14:0], 1'b0} ^ (lfsr_q[15] ? 16'h002D : 16'h0000);
            pend_vld_d = 1'b0;
            // Manual request beats the random candidate; a same-cycle strobe is the freshest
            if (man_ok_c) begin
                trig_c     = 1'b1;
                trig_sel_c = trig_idx;
            end else if (pend_vld_q) begin
                trig_c     = 1'b1;
                trig_sel_c = pend_idx_q;
            end else if (rnd_ok_c) begin
                trig_c     = 1'b1;
                trig_sel_c = {1'b0, lfsr_q[6:0]};
            end
        end
    end

    // Per-channel envelope FSM, PWM accumulator and next active count
    always_comb begin
        cnt_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            st_d[c]   = st_q[c];
            int_d[c]  = int_q[c];
            hcnt_d[c] = hcnt_q[c];
            acc_d[c]  = {1'b0, acc_q[c][IW-1:0]} + {1'b0, int_q[c]};
            if (tick_q) begin
                case (st_q[c])
                    S_IDLE: begin
                        if (trig_c && (trig_sel_c == 8'(c)) && (cnt_q < CW'(MAX_ACTIVE))) begin
                            int_d[c]  = IW'(1);
                            hcnt_d[c] = hold_ticks;
                            st_d[c]   = (FS == IW'(1)) ? S_HOLD : S_RISE;
                        end
                    end
                    S_RISE: begin
                        int_d[c]  = int_q[c] + IW'(1);
                        hcnt_d[c] = hold_ticks;
                        if (int_d[c] == FS) begin
                            st_d[c] = S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (hcnt_q[c] == '0) begin
                            st_d[c] = S_FALL;
                        end else begin
                            hcnt_d[c] = hcnt_q[c] - HOLD_W'(1);
                        end
                    end
                    default: begin
                        int_d[c] = int_q[c] - IW'(1);
                        if (int_q[c] == IW'(1)) begin
                            st_d[c] = S_IDLE;
                        end
                    end
                endcase
            end
            if (st_d[c] != S_IDLE) begin
                cnt_d = cnt_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            tick_q     <= 1'b0;
            lfsr_q     <= 16'hFFFF;
            pend_vld_q <= 1'b0;
            pend_idx_q <= 8'd0;
            cnt_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]   <= S_IDLE;
                int_q[c]  <= '0;
                hcnt_q[c] <= '0;
                acc_q[c]  <= '0;
            end
        end else begin
            div_q      <= div_d;
            tick_q     <= tick_d;
            lfsr_q     <= lfsr_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            cnt_q      <= cnt_d;
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]   <= st_d[c];
                int_q[c]  <= int_d[c];
                hcnt_q[c] <= hcnt_d[c];
                acc_q[c]  <= acc_d[c];
            end
        end
    end

    always_comb begin
        intensities = '0;
        leds        = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            intensities[c*IW +: IW] = int_q[c];
            leds[c]                 = acc_q[c][IW];
        end
    end

    assign tick         = tick_q;
    assign active_count = cnt_q;

endmodule

// File: tb/tb_twinkle_array.sv
// Scoreboard bench for twinkle_array: stimulus pushes per-tick expected snapshots from an
// envelope model, a monitor pops and compares them on every DUT tick.
module tb_twinkle_array;

    localparam int CH = 24;
    localparam int IW = 3;
    localparam int TW = 2;
    localparam int HW = 4;
    localparam int MA = 4;
    localparam int FS = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [7:0]        density;
    logic [HW-1:0]     hold_ticks;
    logic              trig_valid;
    logic [7:0]        trig_idx;
    logic              tick;
    logic [4:0]        active_count;
    logic [CH*IW-1:0]  intensities;
    logic [CH-1:0]     leds;

    twinkle_array #(
        .CHANNELS  (CH),
        .IW        (IW),
        .TICK_WIDTH(TW),
        .HOLD_W    (HW),
        .MAX_ACTIVE(MA)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .density     (density),
        .hold_ticks  (hold_ticks),
        .trig_valid  (trig_valid),
        .trig_idx    (trig_idx),
        .tick        (tick),
        .active_count(active_count),
        .intensities (intensities),
        .leds        (leds)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH*IW-1:0] inten;
        logic [4:0]       cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   start_t[CH];
    int   tcnt     = 0;
    logic pwm_chk  = 1'b0;
    logic cap_chk  = 1'b0;
    logic [3:0] macc;
    int   max_seen = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Intensity n ticks after the trigger tick (n=1 is the first visible step)
    function automatic int env(input int n, input int h);
        if (n < 1) return 0;
        if (n <= FS) return n;
        if (n <= FS + h + 1) return FS;
        if (n <= 2*FS + h + 1) return 2*FS + h + 1 - n;
        return 0;
    endfunction

    function automatic int cur_val(input int c);
        return env(tcnt - start_t[c], int'(hold_ticks));
    endfunction

    function automatic int count_now();
        int a = 0;
        for (int c = 0; c < CH; c++) if (cur_val(c) != 0) a++;
        return a;
    endfunction

    function automatic logic accept_now(input int c);
        return (c < CH) && (cur_val(c) == 0) && (count_now() < MA);
    endfunction

    task automatic push_exp();
        exp_t e;
        int   a = 0;
        int   v;
        e.inten = '0;
        for (int c = 0; c < CH; c++) begin
            v = env(tcnt + 1 - start_t[c], int'(hold_ticks));
            e.inten[c*IW +: IW] = 3'(v);
            if (v != 0) a++;
        end
        e.cnt = 5'(a);
        exp_q.push_back(e);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            trig_valid = 1'b0;
            n++;
        end while (!tick && n < 16);
        check("tick_seen", tick, 1'b1);
        tcnt++;
    endtask

    // Strobe issued in the current tick cycle, so it is applied on this tick
    task automatic man_trig(input int c);
        trig_valid = 1'b1;
        trig_idx   = 8'(c);
        if (accept_now(c)) start_t[c] = tcnt;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        trig_valid = 1'b0;
        trig_idx   = 8'd0;
        enable     = 1'b0;
        density    = 8'd0;
        exp_q.delete();
        pwm_chk = 1'b0;
        cap_chk = 1'b0;
        for (int c = 0; c < CH; c++) start_t[c] = -1000;
        tcnt = 0;
        repeat (3) @(negedge clk);
        check("rst_inten", intensities, '0);
        check("rst_leds", leds, '0);
        check("rst_count", active_count, '0);
        check("rst_tick", tick, 1'b0);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (rst_n && tick && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_inten", intensities, e.inten);
            check("sb_count", active_count, e.cnt);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) macc <= '0;
        else        macc <= {1'b0, macc[2:0]} + {1'b0, intensities[5*IW +: IW]};
    end

    always @(negedge clk) begin
        if (pwm_chk) check("led5_pwm", leds[5], macc[3]);
        if (cap_chk) begin
            check("active_le_cap", active_count <= 5'(MA), 1'b1);
            if (int'(active_count) > max_seen) max_seen = int'(active_count);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        hold_ticks = '0;

        // Reset release and tick cadence
        do_reset();
        repeat (3) begin
            @(negedge clk);
            check("tick_low_pre", tick, 1'b0);
        end
        @(negedge clk); check("tick_first", tick, 1'b1);
        @(negedge clk); check("tick_width", tick, 1'b0);
        repeat (2) @(negedge clk);
        @(negedge clk); check("tick_period", tick, 1'b1);

        // Single envelope on ch5, hold 2, with cycle-level PWM check
        do_reset();
        hold_ticks = 4'd2;
        pwm_chk = 1'b1;
        wait_tick(); man_trig(5); push_exp();
        for (int i = 1; i < 20; i++) begin wait_tick(); push_exp(); end
        wait_tick();
        pwm_chk = 1'b0;

        // Zero hold and the top channel
        do_reset();
        hold_ticks = 4'd0;
        wait_tick(); man_trig(23); push_exp();
        wait_tick(); man_trig(1);  push_exp();
        for (int i = 0; i < 18; i++) begin wait_tick(); push_exp(); end
        wait_tick();

        // Concurrency cap and retrigger of a busy channel
        do_reset();
        hold_ticks = 4'd2;
        for (int i = 0; i < 24; i++) begin
            wait_tick();
            if (i < 6) man_trig(i);
            else if (i == 6) man_trig(0);
            push_exp();
        end
        wait_tick();

        // Pending strobe between ticks: last valid wins, out-of-range ignored
        do_reset();
        hold_ticks = 4'd1;
        wait_tick(); push_exp();
        @(negedge clk); trig_valid = 1'b1; trig_idx = 8'd7;
        @(negedge clk); trig_idx = 8'd9;
        @(negedge clk); trig_idx = 8'd30;
        wait_tick();
        if (accept_now(9)) start_t[9] = tcnt;
        push_exp();
        wait_tick(); man_trig(30); push_exp();
        for (int i = 0; i < 18; i++) begin wait_tick(); push_exp(); end
        wait_tick();

        // Duty at full scale during a long hold, then async reset mid-hold
        do_reset();
        hold_ticks = 4'd15;
        wait_tick(); man_trig(5); push_exp();
        repeat (10) wait_tick();
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (leds[5]) hi++;
            check("other_leds_off", leds & ~24'h000020, '0);
        end
        check("duty_fs", hi, 7);
        #2 rst_n = 1'b0;
        #1;
        check("async_inten", intensities, '0);
        check("async_leds", leds, '0);
        check("async_count", active_count, '0);
        check("async_tick", tick, 1'b0);

        // Density 0 never triggers
        do_reset();
        enable = 1'b1;
        density = 8'd0;
        for (int i = 0; i < 4096; i++) begin wait_tick(); push_exp(); end
        wait_tick();

        // Density 255: random starts happen, cap respected, then drain
        density = 8'd255;
        max_seen = 0;
        cap_chk = 1'b1;
        repeat (300) wait_tick();
        check("random_start_seen", max_seen > 0, 1'b1);
        enable = 1'b0;
        repeat (40) wait_tick();
        cap_chk = 1'b0;
        check("drain_count", active_count, '0);
        check("drain_inten", intensities, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
